// File: rtl/data_memory_arbiter_if.sv
// Bus bundle for the data memory arbiter: CPU port, debug port and memory side.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters plus memory model: drive requests and memory read data.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Shares a single-port synchronous-read data memory between the pipeline
// (prioritised, zero added latency) and a debug unit (req/ack, forced through
// after MAX_WAIT lost cycles). Debug reads are captured one cycle after grant.
module data_memory_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_we_q, dbg_we_d;
    logic              dbg_gnt_s;

    // Debug grant: only in ARB, when the CPU is idle or debug has waited long enough.
    always_comb begin
        dbg_gnt_s = 1'b0;
        if (reset && (state_q == ST_ARB) && bus.dbg_req &&
            (!bus.cpu_req || (wait_cnt_q == MAX_WAIT_C))) begin
            dbg_gnt_s = 1'b1;
        end else begin
            dbg_gnt_s = 1'b0;
        end
    end

    // Memory mux and requester-facing outputs; write enable is suppressed in reset.
    always_comb begin
        bus.cpu_rdata = bus.mem_rdata;
        bus.dbg_rdata = dbg_rdata_q;
        bus.dbg_ack   = (state_q == ST_ACK);
        bus.cpu_stall = bus.cpu_req & dbg_gnt_s;
        if (dbg_gnt_s) begin
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
            bus.mem_we    = bus.dbg_we;
        end else begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_req & bus.cpu_we & reset;
        end
    end

    // Next state, debug read capture and starvation counter.
    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_we_d    = dbg_we_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_ARB: begin
                if (dbg_gnt_s) begin
                    state_d  = ST_CAPTURE;
                    dbg_we_d = bus.dbg_we;
                end else begin
                    state_d  = ST_ARB;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_ACK;
                if (!dbg_we_q) begin
                    dbg_rdata_d = bus.mem_rdata;
                end else begin
                    dbg_rdata_d = dbg_rdata_q;
                end
            end
            ST_ACK: begin
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        if (!bus.dbg_req || dbg_gnt_s) begin
            wait_cnt_d = 8'd0;
        end else if ((state_q == ST_ARB) && (wait_cnt_q < MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_ARB;
            wait_cnt_q  <= 8'd0;
            dbg_rdata_q <= '0;
            dbg_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_we_q    <= dbg_we_d;
        end
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester arbiter and sequencer for the 128 x 32 data memory, sitting between the memory access stage of the pipeline and the single-port data memory. It shares the memory between the pipeline (CPU port, normally prioritised) and the debug unit (request/acknowledge port, starvation-protected). It drives the memory's write-enable, address and write-data inputs. It returns read data to each requester with the memory's one-cycle synchronous read latency accounted for.

## Interface
- ADDR_W, 7: memory address width.
- DATA_W, 32: memory data width.
- MAX_WAIT, 8: cycles a pending debug request may lose to the CPU before it is forced through; legal range 1..255.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU requests an access this cycle.
- cpu_we  in  1  CPU access is a write (1) or a read (0).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; combinational pass-through of mem_rdata.
- cpu_stall  out  1  CPU access not serviced this cycle; pipeline must hold and repeat it.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  debug write (1) or read (0); stable while dbg_req is high.
- dbg_addr  in  ADDR_W  debug address; stable while dbg_req is high.
- dbg_wdata  in  DATA_W  debug write data; stable while dbg_req is high.
- dbg_rdata  out  DATA_W  registered debug read data; valid while dbg_ack is high.
- dbg_ack  out  1  one-cycle completion pulse for the debug access.
- mem_we  out  1  to the memory write enable.
- mem_addr  out  ADDR_W  to the memory address.
- mem_wdata  out  DATA_W  to the memory write data.
- mem_rdata  in  DATA_W  from the memory data output; valid the cycle after the address is presented.

## Operation
- State machine with three states:
  - ARB (reset state).
  - CAPTURE.
  - ACK.
- Debug grant is combinational and occurs only in ARB:
  - dbg_gnt = (state==ARB) & dbg_req & (!cpu_req | wait_cnt==MAX_WAIT).
- Memory mux:
  - When dbg_gnt: mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_we=dbg_we.
  - Otherwise: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req & cpu_we.
- cpu_stall = cpu_req & dbg_gnt. cpu_stall is never asserted in CAPTURE or ACK.
- State transitions:
  - ARB -> CAPTURE on dbg_gnt; otherwise stay in ARB.
  - CAPTURE -> ACK unconditionally. In CAPTURE, dbg_rdata <= mem_rdata if the granted access was a read; it is unchanged for a write.
  - ACK -> ARB unconditionally. dbg_ack=1 only in ACK.
- CAPTURE and ACK leave the memory to the CPU; debug is not eligible for grant in either state.
- wait_cnt is 8 bits:
  - Cleared on dbg_gnt and whenever dbg_req=0.
  - Incremented, saturating at MAX_WAIT, on each ARB cycle with dbg_req=1 and no grant.
- The debug unit drops dbg_req no later than the cycle after dbg_ack. If dbg_req is still high in the next ARB cycle, it is a new request.
- cpu_rdata is valid the cycle after a CPU read that was not stalled. After a stalled cycle, mem_rdata carries debug data; the CPU ignores it.

## Timing
- Reset values, and values held while reset=0:
  - State ARB.
  - wait_cnt=0.
  - dbg_ack=0.
  - dbg_rdata=0.
  - mem_we forced to 0.
  - cpu_stall forced to 0.
- Reset asserted mid debug transaction (CAPTURE or ACK) abandons it: no dbg_ack is issued. A debug write already presented to memory has completed.
- CPU access: zero added latency when not stalled. A read presented in cycle N has data in cycle N+1.
- Debug access granted in cycle G:
  - Memory addressed in G.
  - Data captured at the end of G+1.
  - dbg_ack and dbg_rdata valid in G+2.
  - Earliest next grant is G+3.
- Worst-case debug latency from dbg_req rise to grant is MAX_WAIT cycles under continuous cpu_req.
- Worst-case CPU stall is 1 cycle per debug transaction, at most once every 3 cycles.
- Simultaneous cpu_req and dbg_req with wait_cnt<MAX_WAIT: the CPU wins and wait_cnt increments.

## Test plan
- Reset held low for 3 cycles while cpu_req=1, cpu_we=1 -> mem_we=0, cpu_stall=0, dbg_ack=0, dbg_rdata=0 throughout; no memory write occurs.
- CPU writes 0xDEADBEEF to address 5, then reads address 5 -> cpu_stall=0 on both; cpu_rdata=0xDEADBEEF the cycle after the read.
- CPU idle; debug reads address 5 -> grant in cycle G; dbg_ack=1 for exactly one cycle at G+2 with dbg_rdata=0xDEADBEEF; no re-grant before G+3.
- cpu_req held high continuously; debug writes 0x12345678 to address 0x7F -> 8 cycles with cpu_stall=0, then one cycle with cpu_stall=1 and mem_addr=0x7F, mem_we=1; dbg_ack 2 cycles later; a CPU read of 0x7F then returns 0x12345678.
- Debug read granted; CPU writes address 3 during CAPTURE -> cpu_stall=0, write lands; dbg_ack still at G+2 with the correct debug data.
- Reset asserted during CAPTURE -> no dbg_ack; state returns to ARB; wait_cnt=0; a repeated debug request completes normally.
